serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Framed serial-to-parallel receiver. It samples one bit per `clk` from a single-bit serial line and detects a start bit. It then shifts in `WIDTH` data bits LSB first, optionally checks an even-parity bit, and checks the stop bit. Good frames are presented as a parallel word with a one-cycle `valid` strobe. The block sits at the far end of the team's serial shift chains and turns the bit stream back into words for downstream logic.

## Interface
- `WIDTH`, default 8: data bits per frame; legal range 2..32.
- `clk` input 1: clock. All logic is rising-edge.
- `rst` input 1: reset, synchronous, active-high.
- `si` input 1: serial line. Idles at 1. Sampled once per `clk` edge.
- `data_out` output `WIDTH`: last good received word. Holds until the next good frame.
- `valid` output 1: one-cycle pulse when `data_out` updates.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled 0.
- `parity_err` output 1: one-cycle pulse on parity mismatch. Tied 0 when parity is compiled out.
- `busy` output 1: high in every state except IDLE.

## Operation
- **States:** IDLE, DATA, PARITY, STOP, WAIT_IDLE. PARITY exists only when parity is compiled in.
- **IDLE:** on `si`=0, clear the bit counter and the shift register, then go to DATA. On `si`=1, stay in IDLE.
- **DATA:**
  - Each cycle, shift `si` into the MSB of the shift register, moving the existing contents right one place. After `WIDTH` bits, the first received bit sits in bit 0.
  - A `$clog2(WIDTH)`-bit counter increments each cycle.
  - When the count reaches `WIDTH`-1, go to PARITY (parity compiled in) or STOP (parity compiled out).
- **PARITY:**
  - Sample `si` as the parity bit. The XOR of the data bits and the parity bit must be 0 (even parity).
  - Latch a pending error flag with the result, then go to STOP.
- **STOP:**
  - `si`=1 and no parity error: load `data_out` from the shift register, pulse `valid`, go to IDLE.
  - `si`=1 with a parity error: pulse `parity_err`, leave `data_out` unchanged, go to IDLE.
  - `si`=0: pulse `frame_err`, leave `data_out` unchanged, go to WAIT_IDLE. `frame_err` takes priority; `parity_err` is not also pulsed.
- **WAIT_IDLE:** stay until `si`=1, then go to IDLE. A 0 seen here is never taken as a start bit.
- **Reset:** `rst` overrides all state.
  - Next state is IDLE.
  - `data_out`=0, `valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0.
  - Counter, shift register and pending parity flag are cleared.
  - Reset mid-frame discards the partial frame; no strobe is produced.

## Timing
- **Frame length:** 1 + `WIDTH` + P + 1 cycles, where P=1 with parity and 0 without. That is 11 cycles (parity) or 10 cycles (no parity) at `WIDTH`=8.
- **Cycle numbering:** cycle 0 is the cycle in which `si`=0 is sampled in IDLE.
- **Strobe latency:** `valid`, `frame_err` and `parity_err` are registered. They are high during the cycle immediately after the stop-bit cycle and low in all other cycles.
- **`busy`:** goes high the cycle after the start bit is sampled. It goes low the cycle after the stop bit is sampled (good frame) or after `si` returns to 1 (framing error).
- **Back-to-back frames:** a start bit may occur in the cycle right after a good or parity-errored stop bit. It is accepted with no gap.
- **No in-frame checks:** the line is not checked for glitches inside a frame; data bits are taken as sampled.

## Configuration
- Macro: `SERIAL_FRAME_RX_PARITY_EN`.
- **Defined:**
  - PARITY state present.
  - Frame carries an even-parity bit between the data bits and the stop bit.
  - `parity_err` is live.
- **Undefined:**
  - No PARITY state; DATA goes straight to STOP.
  - Frame is start + data + stop.
  - `parity_err` is constant 0.

## Test plan
- **Reset state:** hold `rst`=1 for 2 cycles with `si`=1 -> all outputs 0 and `busy`=0. `data_out`=0x00.
- **Good frame, parity in, `WIDTH`=8:** send 0, bits 1,0,1,0,0,1,0,1 (0xA5), parity 0, stop 1 -> `valid`=1 in the one cycle after the stop bit, `data_out`=0xA5, no error pulses.
- **Back-to-back:** send 0x3C then 0xFF with no idle gap -> two `valid` pulses exactly 11 cycles apart; `data_out`=0xFF at the end.
- **Parity error:** send 0x01 with parity bit 0 -> `parity_err` pulse, no `valid`, `data_out` keeps its previous value.
- **Framing error:** send 0x55 with stop bit 0, hold `si`=0 for 3 more cycles, then release to 1 -> `frame_err` pulse once. No start bit is accepted until `si`=1. A following good frame 0x12 is received correctly.
- **Reset mid-frame:** assert `rst` during data bit 4, release, then send 0x81 -> no strobe from the aborted frame; 0x81 is received with `valid`.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Framed serial-to-parallel receiver: start bit, WIDTH data bits LSB first,
// optional even-parity bit (SERIAL_FRAME_RX_PARITY_EN), stop bit.
module serial_frame_rx #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             si,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   output logic             frame_err,
   output logic             parity_err,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_DATA      = 3'd1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
   localparam logic [2:0] S_PARITY    = 3'd2;
`endif
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_IDLE = 3'd4;

   logic [2:0]       state;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shreg;

   assign busy = (state != S_IDLE);

`ifdef SERIAL_FRAME_RX_PARITY_EN
   logic perr_pend;
   logic parity_err_q;

   assign parity_err = parity_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         bit_cnt      <= '0;
         shreg        <= '0;
         perr_pend    <= 1'b0;
         data_out     <= '0;
         valid        <= 1'b0;
         frame_err    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         valid        <= 1'b0;
         frame_err    <= 1'b0;
         parity_err_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!si) begin
                  bit_cnt   <= '0;
                  shreg     <= '0;
                  perr_pend <= 1'b0;
                  state     <= S_DATA;
               end
            end
            S_DATA: begin
               // New bits enter at the MSB so the first bit ends up in bit 0.
               shreg   <= {si, shreg[WIDTH-1:1]};
               bit_cnt <= bit_cnt + CW'(1);
               if (bit_cnt == LAST_BIT) state <= S_PARITY;
            end
            S_PARITY: begin
               perr_pend <= (^shreg) ^ si;
               state     <= S_STOP;
            end
            S_STOP: begin
               // A bad stop bit outranks a parity mismatch.
               if (!si) begin
                  frame_err <= 1'b1;
                  state     <= S_WAIT_IDLE;
               end else if (perr_pend) begin
                  parity_err_q <= 1'b1;
                  state        <= S_IDLE;
               end else begin
                  data_out <= shreg;
                  valid    <= 1'b1;
                  state    <= S_IDLE;
               end
            end
            S_WAIT_IDLE: begin
               if (si) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`else

   assign parity_err = 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         data_out  <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!si) begin
                  bit_cnt <= '0;
                  shreg   <= '0;
                  state   <= S_DATA;
               end
            end
            S_DATA: begin
               // New bits enter at the MSB so the first bit ends up in bit 0.
               shreg   <= {si, shreg[WIDTH-1:1]};
               bit_cnt <= bit_cnt + CW'(1);
               if (bit_cnt == LAST_BIT) state <= S_STOP;
            end
            S_STOP: begin
               if (!si) begin
                  frame_err <= 1'b1;
                  state     <= S_WAIT_IDLE;
               end else begin
                  data_out <= shreg;
                  valid    <= 1'b1;
                  state    <= S_IDLE;
               end
            end
            S_WAIT_IDLE: begin
               if (si) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: table of frames, hand-written corner sequences,
// then random frames checked against an outcome model. Inputs change on negedge.
module tb_serial_frame_rx;

   localparam int W = 8;
`ifdef SERIAL_FRAME_RX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FRAME_LEN = 2 + W + P;

   logic         clk = 1'b0;
   logic         rst;
   logic         si;
   logic [W-1:0] data_out;
   logic         valid;
   logic         frame_err;
   logic         parity_err;
   logic         busy;

   serial_frame_rx #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .si         (si),
      .data_out   (data_out),
      .valid      (valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_valid_cyc = 0;
   int valid_gap = 0;

   // Strobes expected in the next sampled cycle, and the expected held word.
   logic         pend_valid = 1'b0;
   logic         pend_ferr  = 1'b0;
   logic         pend_perr  = 1'b0;
   logic [W-1:0] exp_data   = '0;

   typedef struct {
      logic [W-1:0] data;
      logic         flip;
      logic         stop;
      int           zeros_after;
      int           idle_after;
      logic         e_valid;
      logic         e_ferr;
      logic         e_perr;
      logic [W-1:0] e_data;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Every cycle: compare strobes and held data against expectation, then drive.
   task automatic drive_bit(input logic b);
      @(negedge clk);
      cyc++;
      check("valid", {31'd0, valid}, {31'd0, pend_valid});
      check("frame_err", {31'd0, frame_err}, {31'd0, pend_ferr});
      check("parity_err", {31'd0, parity_err}, {31'd0, pend_perr});
      check("data_out", 32'(data_out), 32'(exp_data));
      if (valid) begin
         valid_gap      = cyc - last_valid_cyc;
         last_valid_cyc = cyc;
      end
      pend_valid = 1'b0;
      pend_ferr  = 1'b0;
      pend_perr  = 1'b0;
      si = b;
   endtask

   task automatic send_frame(input logic [W-1:0] d, input logic flip, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < W; i++) drive_bit(d[i]);
`ifdef SERIAL_FRAME_RX_PARITY_EN
      drive_bit(($countones(d) % 2 == 1) ^ flip);
`endif
      drive_bit(stop);
   endtask

   // Outcome model from the frame rules: stop bit first, then parity.
   task automatic expect_outcome(input logic [W-1:0] d, input logic flip, input logic stop);
      logic parity_ok;
      parity_ok = (P == 0) || !flip;
      if (!stop) pend_ferr = 1'b1;
      else if (!parity_ok) pend_perr = 1'b1;
      else begin
         pend_valid = 1'b1;
         exp_data   = d;
      end
   endtask

   initial begin
      vecs.push_back('{8'hA5, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 8'hA5});
      vecs.push_back('{8'h3C, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 8'h3C});
      vecs.push_back('{8'hFF, 1'b0, 1'b1, 0, 2, 1'b1, 1'b0, 1'b0, 8'hFF});
`ifdef SERIAL_FRAME_RX_PARITY_EN
      vecs.push_back('{8'h01, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 1'b1, 8'hFF});
      vecs.push_back('{8'hC3, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 8'hFF});
`endif
      vecs.push_back('{8'h55, 1'b0, 1'b0, 3, 14, 1'b0, 1'b1, 1'b0, 8'hFF});
      vecs.push_back('{8'h12, 1'b0, 1'b1, 0, 2, 1'b1, 1'b0, 1'b0, 8'h12});
      vecs.push_back('{8'h00, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 8'h00});
      vecs.push_back('{8'h80, 1'b0, 1'b0, 0, 3, 1'b0, 1'b1, 1'b0, 8'h00});
      vecs.push_back('{8'h7E, 1'b0, 1'b1, 0, 1, 1'b1, 1'b0, 1'b0, 8'h7E});

      // Reset state
      rst = 1'b1;
      si  = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_data_out", 32'(data_out), 32'h0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("rst_parity_err", {31'd0, parity_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      drive_bit(1'b1);
      drive_bit(1'b1);

      // Table-driven frames
      foreach (vecs[k]) begin
         send_frame(vecs[k].data, vecs[k].flip, vecs[k].stop);
         pend_valid = vecs[k].e_valid;
         pend_ferr  = vecs[k].e_ferr;
         pend_perr  = vecs[k].e_perr;
         if (vecs[k].e_valid) exp_data = vecs[k].e_data;
         for (int z = 0; z < vecs[k].zeros_after; z++) drive_bit(1'b0);
         if (vecs[k].zeros_after > 0) check("busy_wait_idle", {31'd0, busy}, 32'd1);
         for (int j = 0; j < vecs[k].idle_after; j++) drive_bit(1'b1);
      end
      drive_bit(1'b1);
      check("busy_after_table", {31'd0, busy}, 32'd0);
      check("data_after_table", 32'(data_out), 32'h7E);

      // Back-to-back 0x3C then 0xFF
      send_frame(8'h3C, 1'b0, 1'b1);
      expect_outcome(8'h3C, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      expect_outcome(8'hFF, 1'b0, 1'b1);
      drive_bit(1'b1);
      check("b2b_gap", 32'(valid_gap), 32'(FRAME_LEN));
      check("b2b_data", 32'(data_out), 32'hFF);

      // Reset during data bit 4, then 0x81
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      @(negedge clk);
      cyc++;
      check("busy_mid_frame", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      si  = 1'b0;
      @(negedge clk);
      cyc++;
      rst = 1'b0;
      si  = 1'b1;
      exp_data = '0;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_data", 32'(data_out), 32'h0);
      for (int j = 0; j < 3; j++) drive_bit(1'b1);
      send_frame(8'h81, 1'b0, 1'b1);
      expect_outcome(8'h81, 1'b0, 1'b1);
      drive_bit(1'b1);
      check("after_rst_data", 32'(data_out), 32'h81);

      // Random frames against the outcome model
      for (int n = 0; n < 200; n++) begin
         logic [W-1:0] d;
         logic         flip;
         logic         stop;
         int           zeros;
         int           idle;
         d     = W'($urandom);
         flip  = ($urandom_range(0, 3) == 0);
         stop  = ($urandom_range(0, 7) != 0);
         zeros = stop ? 0 : $urandom_range(0, 3);
         idle  = stop ? $urandom_range(0, 2) : $urandom_range(1, 3);
         send_frame(d, flip, stop);
         expect_outcome(d, flip, stop);
         for (int z = 0; z < zeros; z++) drive_bit(1'b0);
         for (int j = 0; j < idle; j++) drive_bit(1'b1);
      end
      for (int j = 0; j < 4; j++) drive_bit(1'b1);
      check("busy_final", {31'd0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
